// File: rtl/iicmb_wb_sequencer.sv
// Sequencer that runs one I2C transaction per request through the IICMB Wishbone registers.
// Define IICMB_SEQ_TIMEOUT_EN to add an irq watchdog that resets the core after TIMEOUT_CYCLES.
module iicmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_rnw_i,
    input  logic [7:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic [7:0]                wr_data_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    output logic [7:0]                rd_data_o,
    output logic                      rd_valid_o,
    output logic                      done_o,
    output logic [1:0]                err_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    typedef enum logic [4:0] {
        S_INIT, S_IDLE, S_BUS_DPR, S_BUS_CMD, S_START, S_ADDR_DPR, S_ADDR_CMD,
        S_WR_FETCH, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_STOP,
        S_WAIT_IRQ, S_STATUS, S_DONE, S_TO_CSR0, S_TO_CSR1
    } state_t;

    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
    localparam logic [WB_DATA_WIDTH-1:0] CSR_ON     = WB_DATA_WIDTH'(8'hC0);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_WRITE  = WB_DATA_WIDTH'(8'h01);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_RD_ACK = WB_DATA_WIDTH'(8'h02);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_RD_NAK = WB_DATA_WIDTH'(8'h03);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_START  = WB_DATA_WIDTH'(8'h04);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_STOP   = WB_DATA_WIDTH'(8'h05);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_SETBUS = WB_DATA_WIDTH'(8'h06);
    localparam logic [LEN_WIDTH-1:0]     LEN_ONE    = LEN_WIDTH'(1);

    state_t                      state, state_nxt, ret, ret_nxt;
    logic [LEN_WIDTH-1:0]        cnt, cnt_nxt;
    logic [1:0]                  err, err_nxt;
    logic                        gap, ack_ok, timeout;
    logic                        wb_acc, wb_we;
    logic [WB_ADDR_WIDTH-1:0]    wb_adr;
    logic [WB_DATA_WIDTH-1:0]    wb_dat;
    logic                        rnw, rd_valid;
    logic [7:0]                  bus, wdata, rd_data;
    logic [I2C_ADDR_WIDTH-1:0]   addr;

    // gap holds off the bus for one cycle after every ack; it is set in reset so outputs stay low
    assign ack_ok = ack_i & ~gap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_INIT;
            ret   <= S_IDLE;
            cnt   <= '0;
            err   <= 2'd0;
            gap   <= 1'b1;
        end else begin
            state <= state_nxt;
            ret   <= ret_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
            gap   <= cyc_o & ack_i;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret;
        cnt_nxt   = cnt;
        err_nxt   = err;
        wb_acc    = 1'b1;
        wb_we     = 1'b1;
        wb_adr    = A_CMDR;
        wb_dat    = '0;
        case (state)
            S_INIT: begin
                wb_adr = A_CSR;
                wb_dat = CSR_ON;
                if (ack_ok) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                wb_acc = 1'b0;
                if (req_valid_i) begin
                    state_nxt = S_BUS_DPR;
                    cnt_nxt   = req_len_i;
                    err_nxt   = 2'd0;
                end
            end
            S_BUS_DPR: begin
                wb_adr = A_DPR;
                wb_dat = WB_DATA_WIDTH'(bus);
                if (ack_ok) state_nxt = S_BUS_CMD;
            end
            S_BUS_CMD: begin
                wb_dat = CMD_SETBUS;
                if (ack_ok) begin state_nxt = S_WAIT_IRQ; ret_nxt = S_START; end
            end
            S_START: begin
                wb_dat = CMD_START;
                if (ack_ok) begin state_nxt = S_WAIT_IRQ; ret_nxt = S_ADDR_DPR; end
            end
            S_ADDR_DPR: begin
                wb_adr = A_DPR;
                wb_dat = WB_DATA_WIDTH'({addr, rnw});
                if (ack_ok) state_nxt = S_ADDR_CMD;
            end
            S_ADDR_CMD: begin
                wb_dat = CMD_WRITE;
                if (ack_ok) begin
                    state_nxt = S_WAIT_IRQ;
                    ret_nxt   = (cnt == '0) ? S_STOP : (rnw ? S_RD_CMD : S_WR_FETCH);
                end
            end
            S_WR_FETCH: begin
                wb_acc = 1'b0;
                if (wr_valid_i) state_nxt = S_WR_DPR;
            end
            S_WR_DPR: begin
                wb_adr = A_DPR;
                wb_dat = WB_DATA_WIDTH'(wdata);
                if (ack_ok) state_nxt = S_WR_CMD;
            end
            S_WR_CMD: begin
                wb_dat = CMD_WRITE;
                if (ack_ok) begin
                    state_nxt = S_WAIT_IRQ;
                    cnt_nxt   = cnt - LEN_ONE;
                    ret_nxt   = (cnt == LEN_ONE) ? S_STOP : S_WR_FETCH;
                end
            end
            S_RD_CMD: begin
                wb_dat = (cnt == LEN_ONE) ? CMD_RD_NAK : CMD_RD_ACK;
                if (ack_ok) begin state_nxt = S_WAIT_IRQ; ret_nxt = S_RD_DPR; end
            end
            S_RD_DPR: begin
                wb_we  = 1'b0;
                wb_adr = A_DPR;
                if (ack_ok) begin
                    cnt_nxt   = cnt - LEN_ONE;
                    state_nxt = (cnt == LEN_ONE) ? S_STOP : S_RD_CMD;
                end
            end
            S_STOP: begin
                wb_dat = CMD_STOP;
                if (ack_ok) begin state_nxt = S_WAIT_IRQ; ret_nxt = S_DONE; end
            end
            S_WAIT_IRQ: begin
                wb_acc = 1'b0;
                if (irq_i)        state_nxt = S_STATUS;
                else if (timeout) state_nxt = S_TO_CSR0;
            end
            S_STATUS: begin
                // NAK still needs a STOP on the wire; AL and ERR leave the bus as it is
                wb_we = 1'b0;
                if (ack_ok) begin
                    if (dat_i[7]) begin
                        state_nxt = ret;
                    end else if (dat_i[6]) begin
                        err_nxt   = 2'd1;
                        state_nxt = (ret == S_DONE) ? S_DONE : S_STOP;
                    end else if (dat_i[5]) begin
                        err_nxt   = 2'd2;
                        state_nxt = S_DONE;
                    end else begin
                        err_nxt   = 2'd3;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                wb_acc    = 1'b0;
                state_nxt = S_IDLE;
            end
            S_TO_CSR0: begin
                wb_adr = A_CSR;
                if (ack_ok) begin state_nxt = S_TO_CSR1; err_nxt = 2'd3; end
            end
            S_TO_CSR1: begin
                wb_adr = A_CSR;
                wb_dat = CSR_ON;
                if (ack_ok) state_nxt = S_DONE;
            end
            default: begin
                wb_acc    = 1'b0;
                state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rnw      <= 1'b0;
            bus      <= 8'd0;
            addr     <= '0;
            wdata    <= 8'd0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == S_IDLE && req_valid_i) begin
                rnw  <= req_rnw_i;
                bus  <= req_bus_i;
                addr <= req_addr_i;
            end
            if (wr_ready_o) wdata <= wr_data_i;
            if (state == S_RD_DPR && ack_ok) begin
                rd_data  <= 8'(dat_i);
                rd_valid <= 1'b1;
            end
        end
    end

`ifdef IICMB_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Restarts from zero each time WAIT_IRQ is entered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                    to_cnt <= '0;
        else if (state != S_WAIT_IRQ) to_cnt <= '0;
        else if (!timeout)            to_cnt <= to_cnt + TO_W'(1);
    end
    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign cyc_o       = wb_acc & ~gap;
    assign stb_o       = cyc_o;
    assign we_o        = cyc_o & wb_we;
    assign adr_o       = cyc_o ? wb_adr : '0;
    assign dat_o       = (cyc_o & wb_we) ? wb_dat : '0;
    assign req_ready_o = (state == S_IDLE);
    assign wr_ready_o  = (state == S_WR_FETCH) & wr_valid_i;
    assign rd_data_o   = rd_data;
    assign rd_valid_o  = rd_valid;
    assign done_o      = (state == S_DONE);
    assign err_o       = done_o ? err : 2'd0;

endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// Randomised scoreboard bench for iicmb_wb_sequencer with an IICMB-like Wishbone slave model.
module tb_iicmb_wb_sequencer;

    localparam int K_CSR = 1, K_SETBUS = 2, K_START = 3, K_BYTE = 4, K_POP = 5;
    localparam int K_RDCMD = 6, K_RDATA = 7, K_STOP = 8, K_DONE = 9, K_BAD = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_rnw = 1'b0;
    logic [7:0] req_bus = 8'd0;
    logic [6:0] req_addr = 7'd0;
    logic [5:0] req_len = 6'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, done;
    logic [1:0] err;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_o, dat_i;
    logic       ack, irq;

    int         n_cmp = 0, n_fail = 0;
    int         done_cnt = 0, pop_cnt = 0;
    int         exp_q[$];
    logic [7:0] wr_q[$], rd_src[$], pay[$];
    logic [7:0] force_resp = 8'd0;
    logic       pop_pending = 1'b0;

    always #5 clk = ~clk;

    iicmb_wb_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_len_i(req_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .done_o(done), .err_o(err),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard pop: every observed event must match the head of the expected stream
    task automatic observe(input string name, input int kind, input int val);
        if (exp_q.size() == 0) checkOutput({name, "_unexpected"}, kind * 256 + val, 0);
        else                   checkOutput(name, kind * 256 + val, exp_q.pop_front());
    endtask

    // Slave model of the IICMB registers: random ack latency, irq after each command
    logic [7:0] bfm_dpr = 8'd0, bfm_resp = 8'd0, resp;
    logic       irq_pend = 1'b0, after_start = 1'b0;
    int         irq_dly = 0, d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0; irq <= 1'b0; irq_pend <= 1'b0; dat_i <= 8'd0;
            after_start <= 1'b0; bfm_dpr <= 8'd0; bfm_resp <= 8'd0;
        end else begin
            ack <= 1'b0;
            if (irq_pend) begin
                if (irq_dly == 0) begin irq <= 1'b1; irq_pend <= 1'b0; end
                else irq_dly <= irq_dly - 1;
            end
            if (cyc && stb && !ack && $urandom_range(0, 2) != 0) begin
                ack <= 1'b1;
                if (we && adr == 2'd1) bfm_dpr <= dat_o;
                else if (we && adr == 2'd2) begin
                    resp = 8'h80;
                    case (dat_o)
                        8'h04: after_start <= 1'b1;
                        8'h01: begin
                            after_start <= 1'b0;
                            if (after_start && bfm_dpr[7:1] == 7'h30) resp = 8'h40;
                            else if (after_start && force_resp != 8'd0) resp = force_resp;
                        end
                        8'h02, 8'h03: bfm_dpr <= (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                        default: ;
                    endcase
                    bfm_resp <= resp;
                    d = $urandom_range(0, 4);
                    if (d == 0) irq <= 1'b1;
                    else begin irq_pend <= 1'b1; irq_dly <= d - 1; end
                end else if (!we) begin
                    dat_i <= (adr == 2'd2) ? bfm_resp : bfm_dpr;
                    if (adr == 2'd2) irq <= 1'b0;
                end
            end
        end
    end

    // Write-byte source: presents bytes with random gaps, drops valid after each capture
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                wr_valid = 1'b0;
            end else if (wr_valid) begin
                if (pop_pending) begin wr_valid = 1'b0; pop_pending = 1'b0; end
            end else if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                wr_data  = wr_q.pop_front();
                wr_valid = 1'b1;
            end
        end
    end

    // Monitor: turns bus traffic and DUT outputs into events for the scoreboard
    logic       prev_ack = 1'b0;
    logic [7:0] shadow_dpr = 8'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) checkOutput("wb_gap", {31'd0, cyc}, 0);
            prev_ack = cyc && stb && ack;
            if (cyc && stb && ack && we) begin
                if (adr == 2'd0) observe("csr", K_CSR, dat_o);
                else if (adr == 2'd1) shadow_dpr = dat_o;
                else if (adr == 2'd2) begin
                    case (dat_o)
                        8'h06: observe("setbus", K_SETBUS, shadow_dpr);
                        8'h04: observe("start", K_START, 0);
                        8'h01: observe("byte", K_BYTE, shadow_dpr);
                        8'h02: observe("rdcmd", K_RDCMD, 0);
                        8'h03: observe("rdcmd", K_RDCMD, 1);
                        8'h05: observe("stop", K_STOP, 0);
                        default: observe("cmd", K_BAD, dat_o);
                    endcase
                end else observe("adr", K_BAD, adr);
            end
            if (wr_valid && wr_ready) begin
                observe("wr_pop", K_POP, wr_data);
                pop_pending = 1'b1;
                pop_cnt++;
            end
            if (rd_valid) observe("rd_data", K_RDATA, rd_data);
            if (done) begin
                observe("done", K_DONE, err);
                done_cnt++;
            end
        end
    end

    // Builds the expected event stream from transaction rules, then issues the request
    task automatic applyStimulus(input logic rnw, input logic [7:0] bus, input logic [6:0] addr,
                                 input int len, input logic [7:0] inj);
        int c;
        exp_q.push_back(K_SETBUS * 256 + bus);
        exp_q.push_back(K_START * 256);
        exp_q.push_back(K_BYTE * 256 + {addr, rnw});
        if (addr == 7'h30) begin
            exp_q.push_back(K_STOP * 256);
            exp_q.push_back(K_DONE * 256 + 1);
        end else if (inj == 8'h20) begin
            exp_q.push_back(K_DONE * 256 + 2);
        end else if (inj == 8'h10) begin
            exp_q.push_back(K_DONE * 256 + 3);
        end else begin
            for (int i = 0; i < len; i++) begin
                if (!rnw) begin
                    wr_q.push_back(pay[i]);
                    exp_q.push_back(K_POP * 256 + pay[i]);
                    exp_q.push_back(K_BYTE * 256 + pay[i]);
                end else begin
                    rd_src.push_back(pay[i]);
                    exp_q.push_back(K_RDCMD * 256 + ((i == len - 1) ? 1 : 0));
                    exp_q.push_back(K_RDATA * 256 + pay[i]);
                end
            end
            exp_q.push_back(K_STOP * 256);
            exp_q.push_back(K_DONE * 256);
        end
        force_resp = inj;
        @(negedge clk);
        req_rnw = rnw; req_bus = bus; req_addr = addr; req_len = 6'(len);
        req_valid = 1'b1;
        c = 0;
        while (!req_ready && c < 3000) begin @(negedge clk); c++; end
        checkOutput("req_accept", {31'd0, req_ready}, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rnw = 1'($urandom); req_bus = 8'($urandom); req_addr = 7'($urandom); req_len = 6'($urandom);
    endtask

    task automatic waitDone(input int base, input string name);
        int c = 0;
        while (done_cnt == base && c < 6000) begin @(negedge clk); c++; end
        checkOutput(name, done_cnt - base, 1);
        @(negedge clk);
        checkOutput({name, "_drained"}, exp_q.size(), 0);
        force_resp = 8'd0;
    endtask

    initial begin
        int base, c, len;
        logic rnw;
        logic [6:0] a;

        repeat (3) @(negedge clk);
        checkOutput("rst_cyc", {31'd0, cyc}, 0);
        checkOutput("rst_stb", {31'd0, stb}, 0);
        checkOutput("rst_we", {31'd0, we}, 0);
        checkOutput("rst_adr", {30'd0, adr}, 0);
        checkOutput("rst_dat", {24'd0, dat_o}, 0);
        checkOutput("rst_ready", {31'd0, req_ready}, 0);
        checkOutput("rst_wr_ready", {31'd0, wr_ready}, 0);
        checkOutput("rst_rd_valid", {31'd0, rd_valid}, 0);
        checkOutput("rst_rd_data", {24'd0, rd_data}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_err", {30'd0, err}, 0);
        exp_q.push_back(K_CSR * 256 + 8'hC0);
        rst = 1'b0;
        c = 0;
        while (!req_ready && c < 200) begin @(negedge clk); c++; end
        checkOutput("init_ready", {31'd0, req_ready}, 1);
        checkOutput("init_drained", exp_q.size(), 0);

        $display("[TB] 32-byte write and read");
        pay.delete(); for (int i = 0; i < 32; i++) pay.push_back(8'(i));
        base = done_cnt; applyStimulus(1'b0, 8'd5, 7'h22, 32, 8'd0); waitDone(base, "wr32_done");
        pay.delete(); for (int i = 0; i < 32; i++) pay.push_back(8'(100 + i));
        base = done_cnt; applyStimulus(1'b1, 8'd5, 7'h22, 32, 8'd0); waitDone(base, "rd32_done");

        $display("[TB] alternating single-byte transfers");
        base = done_cnt;
        for (int k = 0; k < 64; k++) begin
            pay.delete(); pay.push_back(8'(64 + k));
            c = done_cnt; applyStimulus(1'b0, 8'd1, 7'h22, 1, 8'd0); waitDone(c, "alt_wr_done");
            pay.delete(); pay.push_back(8'(63 - k));
            c = done_cnt; applyStimulus(1'b1, 8'd1, 7'h22, 1, 8'd0); waitDone(c, "alt_rd_done");
        end
        checkOutput("alt_done_count", done_cnt - base, 128);

        $display("[TB] NAK, probe, arbitration loss and error");
        pay.delete(); pay.push_back(8'hAA); pay.push_back(8'hBB);
        base = done_cnt; applyStimulus(1'b0, 8'd2, 7'h30, 2, 8'd0); waitDone(base, "nak_wr_done");
        checkOutput("nak_ready_back", {31'd0, req_ready}, 1);
        base = done_cnt; applyStimulus(1'b1, 8'd2, 7'h30, 2, 8'd0); waitDone(base, "nak_rd_done");
        pay.delete();
        base = done_cnt; applyStimulus(1'b0, 8'd5, 7'h22, 0, 8'd0); waitDone(base, "probe_done");
        pay.delete(); pay.push_back(8'h11);
        base = done_cnt; applyStimulus(1'b0, 8'd3, 7'h15, 1, 8'h20); waitDone(base, "al_done");
        base = done_cnt; applyStimulus(1'b1, 8'd3, 7'h16, 1, 8'h10); waitDone(base, "errbit_done");

        $display("[TB] random transactions");
        for (int t = 0; t < 24; t++) begin
            rnw = 1'($urandom);
            len = $urandom_range(0, 7);
            a = 7'($urandom);
            if (a == 7'h30) a = 7'h31;
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            base = done_cnt; applyStimulus(rnw, 8'($urandom), a, len, 8'd0); waitDone(base, "rand_done");
        end

        $display("[TB] reset during write byte 10");
        pay.delete(); for (int i = 0; i < 32; i++) pay.push_back(8'(i));
        base = pop_cnt;
        applyStimulus(1'b0, 8'd5, 7'h22, 32, 8'd0);
        c = 0;
        while (pop_cnt - base < 11 && c < 5000) begin @(negedge clk); c++; end
        checkOutput("rst_reach_byte10", pop_cnt - base, 11);
        c = 0;
        while (!cyc && c < 100) begin @(negedge clk); c++; end
        rst = 1'b1;
        #1;
        checkOutput("midrst_cyc", {31'd0, cyc}, 0);
        checkOutput("midrst_stb", {31'd0, stb}, 0);
        #1;
        exp_q.delete(); wr_q.delete(); rd_src.delete();
        wr_valid = 1'b0; pop_pending = 1'b0; force_resp = 8'd0;
        exp_q.push_back(K_CSR * 256 + 8'hC0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pay.delete(); for (int i = 0; i < 4; i++) pay.push_back(8'(200 + i));
        base = done_cnt; applyStimulus(1'b0, 8'd5, 7'h22, 4, 8'd0); waitDone(base, "post_rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
